eth_fcs_check: RTL

- Receive-side stage that sits directly upstream of the 2-bit CRC32 engine (crc32) in the RMII dibit datapath.
- Takes the raw frame dibit stream and delays it by 16 dibits so the 32-bit FCS never reaches downstream.
- Feeds the payload dibits into an internal crc32 instance.
- At end of frame, compares the computed CRC against the 16 trailing FCS dibits and emits a one-cycle done/kill verdict.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_fcs_check_if.sv | 29 ++
 rtl/crc32.sv | 26 ++
 rtl/fcs_delay_line.sv | 28 ++
 rtl/eth_fcs_check.sv | 130 +++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, state type and CRC helpers for the Ethernet FCS checker
package eth_pkg;

  localparam int          FCS_DIBITS = 16;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} fcs_state_t;

  // One serial step of the MSB-first CRC32 register.
  function automatic logic [31:0] crc_bit_step(input logic [31:0] crc, input logic b);
    return {crc[30:0], 1'b0} ^ ((crc[31] ^ b) ? CRC_POLY : 32'h0);
  endfunction

  // FCS dibit k carries {crc[30-2k], crc[31-2k]}, i.e. the bit-reversed word.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    return {<<{v}};
  endfunction

endpackage

// File: rtl/eth_fcs_check_if.sv
// rtl/eth_fcs_check_if.sv - dibit stream in, stripped stream and verdict out; stats ports under FCS_CHECK_STATS_EN
interface eth_fcs_check_if;
  logic       axiiv;
  logic [1:0] axiid;
  logic       axiov;
  logic [1:0] axiod;
  logic       done;
  logic       kill;
`ifdef FCS_CHECK_STATS_EN
  logic [15:0] good_count;
  logic [15:0] bad_count;
`endif

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, done, kill
`ifdef FCS_CHECK_STATS_EN
    , output good_count, bad_count
`endif
  );

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, done, kill
`ifdef FCS_CHECK_STATS_EN
    , input good_count, bad_count
`endif
  );
endinterface

// File: rtl/crc32.sv
// rtl/crc32.sv - 2-bit-per-cycle CRC32 engine, axiid[0] consumed first
module crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [31:0] axiod
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (axiiv) crc_d = crc_bit_step(crc_bit_step(crc_q, axiid[0]), axiid[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign axiod = crc_q;

endmodule

// File: rtl/fcs_delay_line.sv
// rtl/fcs_delay_line.sv - 16-deep dibit shift register; entry 0 is the oldest and is evicted on shift
module fcs_delay_line
  import eth_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic [1:0]                  din,
  output logic [1:0]                  evicted,
  output logic [FCS_DIBITS-1:0][1:0]  entries
);

  logic [FCS_DIBITS-1:0][1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (shift_en) line_d = {din, line_q[FCS_DIBITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) line_q <= '0;
    else     line_q <= line_d;
  end

  assign evicted = line_q[0];
  assign entries = line_q;

endmodule

// File: rtl/eth_fcs_check.sv
// rtl/eth_fcs_check.sv - strips and checks the 32-bit Ethernet FCS on an RMII dibit stream; FCS_CHECK_STATS_EN adds counters
module eth_fcs_check
  import eth_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  eth_fcs_check_if.slave  s
);

  fcs_state_t state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       axiov_q, axiov_d;
  logic [1:0] axiod_q, axiod_d;
  logic       done_q,  done_d;
  logic       kill_q,  kill_d;

  logic                       evict;
  logic                       end_cycle;
  logic                       crc_rst;
  logic                       fcs_ok;
  logic [1:0]                 evicted;
  logic [FCS_DIBITS-1:0][1:0] entries;
  logic [31:0]                crc_raw;

  assign evict     = s.axiiv && (state_q == STREAM);
  assign end_cycle = !s.axiiv && (state_q != IDLE);
  assign crc_rst   = rst || end_cycle;
  assign fcs_ok    = (entries == bit_reverse32(~crc_raw));

  fcs_delay_line u_delay (
    .clk      (clk),
    .rst      (rst),
    .shift_en (s.axiiv),
    .din      (s.axiid),
    .evicted  (evicted),
    .entries  (entries)
  );

  crc32 u_crc (
    .clk   (clk),
    .rst   (crc_rst),
    .axiiv (evict),
    .axiid (evicted),
    .axiod (crc_raw)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    axiov_d = evict;
    axiod_d = evict ? evicted : 2'b00;
    done_d  = end_cycle;
    // A frame that ends before the line is full is a runt regardless of content.
    kill_d  = end_cycle && ((state_q == FILL) || !fcs_ok);
    case (state_q)
      IDLE: begin
        if (s.axiiv) begin
          state_d = FILL;
          count_d = 4'd1;
        end
      end
      FILL: begin
        if (!s.axiiv) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == 4'(FCS_DIBITS - 1)) begin
          state_d = STREAM;
        end else begin
          count_d = count_q + 4'd1;
        end
      end
      STREAM: begin
        if (!s.axiiv) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

`ifdef FCS_CHECK_STATS_EN
  logic [15:0] good_q, good_d, bad_q, bad_d;

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (done_d && kill_d && (bad_q != 16'hFFFF))   bad_d  = bad_q + 16'd1;
    if (done_d && !kill_d && (good_q != 16'hFFFF)) good_d = good_q + 16'd1;
  end

  assign s.good_count = good_q;
  assign s.bad_count  = bad_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      axiov_q <= 1'b0;
      axiod_q <= 2'b00;
      done_q  <= 1'b0;
      kill_q  <= 1'b0;
`ifdef FCS_CHECK_STATS_EN
      good_q  <= '0;
      bad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      done_q  <= done_d;
      kill_q  <= kill_d;
`ifdef FCS_CHECK_STATS_EN
      good_q  <= good_d;
      bad_q   <= bad_d;
`endif
    end
  end

  assign s.axiov = axiov_q;
  assign s.axiod = axiod_q;
  assign s.done  = done_q;
  assign s.kill  = kill_q;

endmodule
